// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding command initiator for a register-bus
// core chain, with response timeout plus transaction and error counters.
module bus_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd_addr_i,
    input  logic [15:0] cmd_data_i,
    input  logic        cmd_rw_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [15:0] rsp_addr_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_rw_o,
    output logic        rsp_timeout_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] txn_count_o,
    output logic [7:0]  err_count_o
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

    state_t      r_state, w_state_n;
    logic [15:0] r_addr, w_addr_n;
    logic [15:0] r_data, w_data_n;
    logic        r_rw, w_rw_n;
    logic [15:0] r_cnt, w_cnt_n;
    logic        r_cmd_ready, w_cmd_ready_n;
    logic [15:0] r_addr_o, w_addr_o_n;
    logic [15:0] r_data_o, w_data_o_n;
    logic        r_rw_o, w_rw_o_n;
    logic        r_valid_o, w_valid_o_n;
    logic [15:0] r_rsp_addr, w_rsp_addr_n;
    logic [15:0] r_rsp_data, w_rsp_data_n;
    logic        r_rsp_rw, w_rsp_rw_n;
    logic        r_rsp_to, w_rsp_to_n;
    logic        r_rsp_valid, w_rsp_valid_n;
    logic [15:0] r_txn, w_txn_n;
    logic [7:0]  r_err, w_err_n;
    logic        w_ok;
    logic        w_to;

    // A match only counts while the transaction is on the chain; it beats expiry.
    assign w_ok = valid_i && (addr_i == r_addr) && (rw_i == r_rw)
               && ((r_state == S_ISSUE) || (r_state == S_WAIT));
    assign w_to = !w_ok && (r_state == S_WAIT) && (r_cnt == LP_LAST);

    always_comb begin
        w_state_n     = r_state;
        w_addr_n      = r_addr;
        w_data_n      = r_data;
        w_rw_n        = r_rw;
        w_cnt_n       = r_cnt;
        w_cmd_ready_n = r_cmd_ready;
        w_addr_o_n    = r_addr_o;
        w_data_o_n    = r_data_o;
        w_rw_o_n      = r_rw_o;
        w_valid_o_n   = r_valid_o;
        w_rsp_addr_n  = r_rsp_addr;
        w_rsp_data_n  = r_rsp_data;
        w_rsp_rw_n    = r_rsp_rw;
        w_rsp_to_n    = r_rsp_to;
        w_rsp_valid_n = r_rsp_valid;
        w_txn_n       = r_txn;
        w_err_n       = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_state_n     = S_ISSUE;
                    w_addr_n      = cmd_addr_i;
                    w_data_n      = cmd_data_i;
                    w_rw_n        = cmd_rw_i;
                    w_cnt_n       = 16'd0;
                    w_cmd_ready_n = 1'b0;
                    w_addr_o_n    = cmd_addr_i;
                    w_data_o_n    = cmd_data_i;
                    w_rw_o_n      = cmd_rw_i;
                    w_valid_o_n   = 1'b1;
                end
            end
            S_ISSUE: begin
                w_addr_o_n  = 16'd0;
                w_data_o_n  = 16'd0;
                w_rw_o_n    = 1'b0;
                w_valid_o_n = 1'b0;
                w_cnt_n     = 16'd0;
                w_state_n   = w_ok ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (w_ok || w_to) begin
                    w_state_n = S_RESP;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_n     = S_IDLE;
                    w_cmd_ready_n = 1'b1;
                    w_rsp_valid_n = 1'b0;
                    w_rsp_addr_n  = 16'd0;
                    w_rsp_data_n  = 16'd0;
                    w_rsp_rw_n    = 1'b0;
                    w_rsp_to_n    = 1'b0;
                    w_txn_n       = r_txn + 16'd1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_ok || w_to) begin
            w_rsp_valid_n = 1'b1;
            w_rsp_addr_n  = r_addr;
            w_rsp_rw_n    = r_rw;
            w_rsp_to_n    = w_to;
            w_rsp_data_n  = w_to ? 16'd0 : (r_rw ? r_data : data_i);
        end
        if (w_to && (r_err != 8'hFF)) begin
            w_err_n = r_err + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 16'd0;
            r_data      <= 16'd0;
            r_rw        <= 1'b0;
            r_cnt       <= 16'd0;
            r_cmd_ready <= 1'b1;
            r_addr_o    <= 16'd0;
            r_data_o    <= 16'd0;
            r_rw_o      <= 1'b0;
            r_valid_o   <= 1'b0;
            r_rsp_addr  <= 16'd0;
            r_rsp_data  <= 16'd0;
            r_rsp_rw    <= 1'b0;
            r_rsp_to    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_txn       <= 16'd0;
            r_err       <= 8'd0;
        end else begin
            r_state     <= w_state_n;
            r_addr      <= w_addr_n;
            r_data      <= w_data_n;
            r_rw        <= w_rw_n;
            r_cnt       <= w_cnt_n;
            r_cmd_ready <= w_cmd_ready_n;
            r_addr_o    <= w_addr_o_n;
            r_data_o    <= w_data_o_n;
            r_rw_o      <= w_rw_o_n;
            r_valid_o   <= w_valid_o_n;
            r_rsp_addr  <= w_rsp_addr_n;
            r_rsp_data  <= w_rsp_data_n;
            r_rsp_rw    <= w_rsp_rw_n;
            r_rsp_to    <= w_rsp_to_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_txn       <= w_txn_n;
            r_err       <= w_err_n;
        end
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign addr_o        = r_addr_o;
    assign data_o        = r_data_o;
    assign rw_o          = r_rw_o;
    assign valid_o       = r_valid_o;
    assign rsp_addr_o    = r_rsp_addr;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_rw_o      = r_rsp_rw;
    assign rsp_timeout_o = r_rsp_to;
    assign rsp_valid_o   = r_rsp_valid;
    assign txn_count_o   = r_txn;
    assign err_count_o   = r_err;
endmodule
